// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e : MDOp encodings driven by the E-stage decoder
//   - default busy-cycle counts for multiply and divide
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit; owns the HI/LO registers.
//
// The result is computed combinationally in the Start cycle and parked in
// pending registers; a down-counter models the iterative latency and the
// pending value is committed to HI/LO on the edge where Busy falls.
//
// Ports:
//   Clk       core clock
//   Reset     asynchronous active-high reset
//   Start     E-stage mult/multu/div/divu this cycle
//   MDOp      operation select (md_op_e)
//   A, B      forwarded rs / rt operands
//   HIWrite   mthi: HI <= A
//   LOWrite   mtlo: LO <= A
//   Req       exception flush; blocks Start/HIWrite/LOWrite this cycle
//   HILOSel   0 -> LO, 1 -> HI on HILO_Out
//   Busy      operation in progress
//   HI, LO    committed registers
//   HILO_Out  HILOSel ? HI : LO (committed values only)
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        Req,
  input  logic        HILOSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e             r_state;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_phi;
  logic [31:0]        r_plo;
  logic               r_pwr;   // pending result should be committed

  logic               w_accept;
  logic               w_op_valid;
  logic               w_is_div;
  logic               w_div_ovf;
  logic [31:0]        w_b_safe;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_wr;

  // New work is only taken while idle and not being flushed.
  assign w_accept = (r_state == ST_IDLE) && !Req;

  // The -2^31 / -1 case and divide-by-zero are steered onto a harmless
  // divisor so the divider never sees an overflowing or undefined operation;
  // their architectural results are patched in below.
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_b_safe  = ((B == 32'd0) || w_div_ovf) ? 32'd1 : B;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_q_s    = $signed(A) / $signed(w_b_safe);
  assign w_r_s    = $signed(A) % $signed(w_b_safe);
  assign w_q_u    = A / w_b_safe;
  assign w_r_u    = A % w_b_safe;

  always_comb begin
    w_op_valid = 1'b0;
    w_is_div   = 1'b0;
    w_res_hi   = 32'd0;
    w_res_lo   = 32'd0;
    w_res_wr   = 1'b0;
    case (MDOp)
      MD_MULT: begin
        w_op_valid = 1'b1;
        w_res_hi   = w_prod_s[63:32];
        w_res_lo   = w_prod_s[31:0];
        w_res_wr   = 1'b1;
      end
      MD_MULTU: begin
        w_op_valid = 1'b1;
        w_res_hi   = w_prod_u[63:32];
        w_res_lo   = w_prod_u[31:0];
        w_res_wr   = 1'b1;
      end
      MD_DIV: begin
        w_op_valid = 1'b1;
        w_is_div   = 1'b1;
        w_res_hi   = w_div_ovf ? 32'd0 : w_r_s;
        w_res_lo   = w_div_ovf ? 32'h8000_0000 : w_q_s;
        w_res_wr   = (B != 32'd0);
      end
      MD_DIVU: begin
        w_op_valid = 1'b1;
        w_is_div   = 1'b1;
        w_res_hi   = w_r_u;
        w_res_lo   = w_q_u;
        w_res_wr   = (B != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pwr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (Start) begin
              // Start wins over mthi/mtlo; unknown opcodes are dropped.
              if (w_op_valid) begin
                r_phi   <= w_res_hi;
                r_plo   <= w_res_lo;
                r_pwr   <= w_res_wr;
                r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
              end
            end else begin
              if (HIWrite) r_hi <= A;
              if (LOWrite) r_lo <= A;
            end
          end
        end
        ST_RUN: begin
          // Req is deliberately ignored here: the running op is older.
          if (r_cnt == CNT_W'(1)) begin
            if (r_pwr) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign HILO_Out = HILOSel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit with hand-computed results.
module tb_md_unit;
  import md_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        Req;
  logic        HILOSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HILO_Out;

  int n_checks = 0;
  int n_errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .HIWrite  (HIWrite),
    .LOWrite  (LOWrite),
    .Req      (Req),
    .HILOSel  (HILOSel),
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO),
    .HILO_Out (HILO_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; Req = 1'b0;
    MDOp = 3'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic do_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    clear_in();
  endtask

  task automatic do_write(input logic hw, input logic lw, input logic rq, input logic [31:0] a);
    HIWrite = hw; LOWrite = lw; Req = rq; A = a;
    step();
    clear_in();
  endtask

  // Counts further rising edges until Busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 200) begin
      step();
      n++;
    end
    if (Busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  int n;

  initial begin
    clear_in();
    HILOSel = 1'b0;
    Reset   = 1'b1;
    repeat (2) @(posedge Clk);
    #3 Reset = 1'b0;
    step();
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // mtlo suppressed by Req, then accepted
    do_write(1'b0, 1'b1, 1'b1, 32'h1234);
    chk("mtlo_req_lo", LO, 32'd0);
    do_write(1'b0, 1'b1, 1'b0, 32'h1234);
    chk("mtlo_lo", LO, 32'h1234);
    HILOSel = 1'b0; #1;
    chk("mtlo_hilo_out", HILO_Out, 32'h1234);
    do_write(1'b1, 1'b0, 1'b0, 32'h55);
    chk("mthi_hi", HI, 32'h55);
    HILOSel = 1'b1; #1;
    chk("mthi_hilo_out", HILO_Out, 32'h55);

    // mult -1 * 2; committed HI still visible while busy
    do_start(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_busy_rise", {31'd0, Busy}, 32'd1);
    chk("mult_no_forward", HILO_Out, 32'h55);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    do_start(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_busy_cycles", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    do_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", n, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    do_start(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);

    // simultaneous mthi+mtlo, then set up for divide-by-zero
    do_write(1'b1, 1'b1, 1'b0, 32'h77);
    chk("both_wr_hi", HI, 32'h77);
    chk("both_wr_lo", LO, 32'h77);
    do_write(1'b1, 1'b0, 1'b0, 32'h11);
    do_write(1'b0, 1'b1, 1'b0, 32'h22);
    do_start(MD_DIVU, 32'd100, 32'd0);
    wait_idle(n);
    chk("divz_busy_cycles", n, 32'd10);
    chk("divz_hi", HI, 32'h11);
    chk("divz_lo", LO, 32'h22);

    do_start(MD_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // Start and mtlo during busy are ignored
    do_start(MD_MULT, 32'd3, 32'd4);
    step();
    Start = 1'b1; MDOp = MD_DIVU; A = 32'd100; B = 32'd7; LOWrite = 1'b1;
    step();
    clear_in();
    wait_idle(n);
    chk("busy_start_cycles", n + 2, 32'd5);
    chk("busy_start_hi", HI, 32'd0);
    chk("busy_start_lo", LO, 32'd12);

    // Req during RUN does not abort
    do_start(MD_MULT, 32'd6, 32'd7);
    Req = 1'b1;
    step();
    step();
    Req = 1'b0;
    wait_idle(n);
    chk("req_run_cycles", n + 2, 32'd5);
    chk("req_run_lo", LO, 32'd42);

    // Start with Req blocked
    Req = 1'b1;
    do_start(MD_MULT, 32'd9, 32'd9);
    chk("req_start_busy", {31'd0, Busy}, 32'd0);

    // unknown opcode stays idle
    do_start(3'd5, 32'd9, 32'd9);
    chk("badop_busy", {31'd0, Busy}, 32'd0);
    chk("badop_lo", LO, 32'd42);

    // asynchronous reset in cycle 3 of a mult
    do_start(MD_MULT, 32'd5, 32'd5);
    step();
    step();
    Reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    #1 Reset = 1'b0;
    step();
    chk("arst_stays_idle", {31'd0, Busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core. It owns the HI/LO architectural registers.
- It accepts mult/multu/div/divu/mthi/mtlo from the E stage and drives the value latched into the E/M pipeline register's HILO field.
- Busy feeds the D-stage hazard unit, which stalls later HI/LO-using instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- Clk  input  1  core clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  E-stage instruction is mult/multu/div/divu this cycle
- MDOp  input  3  operation select (package encoding)
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- HIWrite  input  1  mthi: write A into HI
- LOWrite  input  1  mtlo: write A into LO
- Req  input  1  exception/interrupt flush; suppresses Start/HIWrite/LOWrite this cycle
- HILOSel  input  1  0 selects LO, 1 selects HI on HILO_Out
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- HILO_Out  output  32  HILOSel ? HI : LO, combinational (mfhi/mflo path to E/M register)

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
  - On Reset: HI=0, LO=0, Busy=0, counter=0, pending result registers=0, pending-op=none.
- States: IDLE and RUN. Busy=1 exactly in RUN.
- IDLE, Start=1 and Req=0:
  - Capture the result computed from A/B into pending registers (pHI, pLO).
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - Busy rises on the next edge.
- RUN: counter decrements each cycle. When counter==1 on a clock edge:
  - commit pHI/pLO to HI/LO,
  - go to IDLE,
  - Busy falls on that same edge.
  - Busy is therefore high for exactly N cycles. The new HI/LO are visible in the first cycle with Busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: unsigned 32x32 -> 64; same HI/LO split.
  - div: signed, quotient truncates toward zero; LO = quotient, HI = remainder, remainder takes the sign of the dividend.
  - div -2^31 / -1: LO = 0x80000000, HI = 0.
  - divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (div or divu with B==0):
  - Busy still runs DIV_CYCLES.
  - HI and LO are left unchanged at commit.
- mthi/mtlo:
  - Accepted only in IDLE with Req=0.
  - Write A into HI or LO on the next edge; no Busy.
  - If HIWrite and LOWrite are both asserted, both registers take A.
  - If Start is asserted with HIWrite or LOWrite in the same cycle, Start takes priority and the writes are dropped. The decoder never generates this combination.
- Start, HIWrite or LOWrite while Busy: ignored, with no state change. The hazard unit prevents this case, and the block must be robust to it.
- Req=1: blocks any new Start or write in that cycle. Req does not abort an operation already in RUN, because that instruction is older than the faulting one.
- HILO_Out reflects the committed HI/LO only. It is never forwarded from pending results.
- MDOp values outside the four arithmetic encodings, with Start=1: ignored; stay IDLE.

Decomposition:
- Shared package md_pkg holds:
  - MDOp encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3.
  - Default cycle-count constants.
- No sub-module. The block is a single module: state register, counter, pending result registers, and result datapath.

Test Plan:
- Reset asserted mid-RUN (cycle 3 of mult) -> Busy=0, HI=LO=0 immediately, with no clock edge required.
- mult A=0xFFFFFFFF (-1), B=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0, prior HI=0x11, LO=0x22 -> Busy 10 cycles; HI/LO stay 0x11/0x22.
- mtlo A=0x1234 with Req=1 -> LO unchanged.
- mtlo A=0x1234 with Req=0 -> LO=0x1234 next cycle; HILOSel=0 gives HILO_Out=0x1234.
- Start during Busy -> ignored; original result commits on schedule.
